mem_dma: RTL
============

// Module: mem_dma
// PURPOSE
//  Upstream driver for the 256x8 single-port synchronous memory: owns its MemRead/MemWrite/ADDR/Data_in.
//  Idle: CPU requests pass straight through. Busy: runs a block COPY (src->dst) or FILL (constant) of LEN bytes.
//  CPU sees cpu_stall while busy. All memory traffic uses the memory's rules.
//  Memory rules: write wins over read; read data valid the cycle after MemRead; Data_out holds otherwise.
// PARAMETERS
//  AW  8  address width; memory depth 2**AW, all address arithmetic modulo 2**AW
//  DW  8  data width
// PORTS
//  CLK         in   1     clock, all state on posedge
//  RST         in   1     synchronous, active-high reset
//  cpu_read    in   1     CPU read strobe (pass-through when idle)
//  cpu_write   in   1     CPU write strobe (pass-through when idle)
//  cpu_addr    in   AW    CPU address
//  cpu_wdata   in   DW    CPU write data
//  cpu_rdata   out  DW    = mem_rdata, unregistered
//  cpu_stall   out  1     = busy; CPU strobes ignored while high
//  start       in   1     launch request, sampled only in IDLE
//  mode        in   1     0 = COPY, 1 = FILL
//  src         in   AW    COPY source base address
//  dst         in   AW    destination base address
//  len         in   AW+1  byte count 0..2**AW
//  fill_val    in   DW    FILL data
//  busy        out  1     engine active
//  done        out  1     one-cycle completion pulse
//  MemRead     out  1     to memory
//  MemWrite    out  1     to memory
//  ADDR        out  AW    to memory
//  Data_in     out  DW    to memory
//  mem_rdata   in   DW    from memory Data_out
// BEHAVIOUR
//  Reset: state=IDLE; busy=0; done=0; internal counters/regs=0.
//  Reset: MemRead=MemWrite=0 combinationally whenever RST=1, in any state.
//  IDLE: MemRead=cpu_read, MemWrite=cpu_write, ADDR=cpu_addr, Data_in=cpu_wdata (combinational mux).
//  Launch: start=1 in IDLE latches mode/src/dst/fill_val; cnt=len.
//  Launch, len=0: go to DONE, no memory access.
//  Launch, len>0: COPY -> RD; FILL -> WR.
//  Busy: start ignored while busy; no queuing.
//  RD: MemRead=1, ADDR=sa, MemWrite=0; next -> WR.
//  WR: MemWrite=1, ADDR=da, MemRead=0.
//  WR data: Data_in = mem_rdata (COPY) or fill_val (FILL).
//  WR update: da+=1, sa+=1, cnt-=1; cnt==1 -> DONE, else -> RD (COPY) or WR (FILL).
//  DONE: done=1 for exactly one cycle, no memory strobes; next -> IDLE.
//  Throughput: COPY 2 cycles/byte; FILL 1 cycle/byte.
//  Latency: start edge to done high = 2*len+1 cycles (COPY), len+1 (FILL), 1 (len=0).
//  busy: high in RD/WR/DONE; cpu_stall=busy; CPU strobes in these states never reach memory.
//  Wrap: sa/da wrap 0xFF->0x00 silently; len=256 covers whole memory.
//  Overlap: COPY strictly ascending, byte-at-a-time.
//  Overlap with dst in (src, src+len): source bytes replicate forward (defined, not an error).
//  RST mid-operation: abort to IDLE at that edge; no done pulse; already-written bytes stay written.
// STRUCTURE
//  mem_dma_pkg: state encoding (IDLE, RD, WR, DONE), MODE_COPY/MODE_FILL constants.
//  Single module, no sub-modules: one FSM, sa/da/cnt registers, output mux.
//  Bench instantiates mem_dma with the memory module as the DUT pair.
// TESTING
//  1. CPU write 0x5A @0x10 then read @0x10 while idle -> cpu_rdata=0x5A the following cycle; cpu_stall=0.
//  2. FILL dst=0x20 len=4 val=0xA5 -> 0x20..0x23=0xA5; 0x24 untouched; done 5 cycles after start; busy 4+1 cycles.
//  3. COPY src=0x00 dst=0x80 len=3 (pre-loaded 11,22,33) -> 0x80..0x82=11,22,33; done at cycle 7; MemRead/MemWrite alternate.
//  4. COPY src=0xFE dst=0x10 len=4 -> reads FE,FF,00,01; writes 0x10..0x13; ADDR wraps correctly.
//  5. len=0 -> done pulse next cycle; zero MemRead/MemWrite cycles.
//  6. COPY len=8, RST asserted after 3rd write -> busy=0 and done=0 after edge; only 3 bytes written.
//  6 (cont). cpu_write during busy is absent from the memory trace; start while busy ignored.

Source files
------------

// File: rtl/mem_dma_pkg.sv
// Shared definitions for the block copy/fill engine that fronts the 256x8 memory.
// Holds the FSM state encoding and the operating-mode constants.
package mem_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_dma.sv
// Memory-side driver: forwards CPU accesses when idle, otherwise runs a byte-wise
// COPY (read then write per byte) or FILL (one write per byte) over len bytes.
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          cpu_read,
    input  logic          cpu_write,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW:0]   len,
    input  logic [DW-1:0] fill_val,
    output logic          busy,
    output logic          done,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [AW-1:0] ADDR,
    output logic [DW-1:0] Data_in,
    input  logic [DW-1:0] mem_rdata
);

    state_e        state_q;
    logic          mode_q;
    logic [AW-1:0] sa_q;
    logic [AW-1:0] da_q;
    logic [AW:0]   cnt_q;
    logic [DW-1:0] fill_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_COPY;
            sa_q    <= '0;
            da_q    <= '0;
            cnt_q   <= '0;
            fill_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        sa_q   <= src;
                        da_q   <= dst;
                        cnt_q  <= len;
                        fill_q <= fill_val;
                        if (len == '0)
                            state_q <= ST_DONE;
                        else if (mode == MODE_FILL)
                            state_q <= ST_WR;
                        else
                            state_q <= ST_RD;
                    end
                end
                ST_RD: state_q <= ST_WR;
                ST_WR: begin
                    // Addresses are AW bits wide, so they wrap modulo 2**AW for free.
                    sa_q  <= sa_q + 1'b1;
                    da_q  <= da_q + 1'b1;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == (AW+1)'(1))
                        state_q <= ST_DONE;
                    else if (mode_q == MODE_FILL)
                        state_q <= ST_WR;
                    else
                        state_q <= ST_RD;
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign cpu_stall = busy;
    assign cpu_rdata = mem_rdata;

    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ADDR     = cpu_addr;
        Data_in  = cpu_wdata;
        case (state_q)
            ST_IDLE: begin
                MemRead  = cpu_read;
                MemWrite = cpu_write;
            end
            ST_RD: begin
                MemRead = 1'b1;
                ADDR    = sa_q;
            end
            ST_WR: begin
                MemWrite = 1'b1;
                ADDR     = da_q;
                // In COPY the byte read in RD is on mem_rdata during this cycle.
                Data_in  = (mode_q == MODE_FILL) ? fill_q : mem_rdata;
            end
            ST_DONE: ADDR = da_q;
            default: ;
        endcase
        if (RST) begin
            MemRead  = 1'b0;
            MemWrite = 1'b0;
        end
    end

endmodule
